// File: rtl/concurrency_guard_pkg.sv
// Shared bus command encoding and guard arbitration states.
// Imported by the concurrency guard, its detector and its interface.
package commands;

  typedef enum logic [2:0] {
    NONE,
    BUS_READ,
    BUS_READ_EXCLUSIVE,
    BUS_INVALIDATE,
    BUS_WRITEBACK
  } Command;

  function automatic logic is_exclusive(
    input Command c
  );
    return (c == BUS_INVALIDATE) ||
           (c == BUS_READ_EXCLUSIVE);
  endfunction

endpackage

package concurrency_guard_types;

  typedef enum logic [1:0] {
    IDLE,
    SNOOP_OWNS,
    CPU_OWNS
  } guard_state_t;

endpackage

// File: rtl/concurrency_guard_if.sv
// CPU-side and snoop-side request bundle around the guard.
// The guard sits on the slave side and gates requests through.
interface concurrency_guard_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int SNOOP_PORTS = 2
);
  import commands::*;

  logic [ADDRESS_WIDTH-1:0] cpuAddress;
  logic cpuReadEnabledIn;
  logic cpuWriteEnabledIn;
  logic cpuReadEnabledOut;
  logic cpuWriteEnabledOut;
  logic cpuFunctionComplete;
  logic cpuHit;
  Command cpuCommandOut;
  logic cpuGrant;

  logic [ADDRESS_WIDTH-1:0] snoopAddress [SNOOP_PORTS];
  Command snoopCommandIn [SNOOP_PORTS];
  Command snoopCommandOut [SNOOP_PORTS];
  logic [SNOOP_PORTS-1:0] snoopHit;
  logic [SNOOP_PORTS-1:0] snoopIsInvalidatedIn;
  logic [SNOOP_PORTS-1:0] snoopIsInvalidatedOut;
  logic [SNOOP_PORTS-1:0] snoopReadEnabledIn;
  logic [SNOOP_PORTS-1:0] snoopReadEnabledOut;

  logic starvationEvent;

  modport master (
    output cpuAddress,
    output cpuReadEnabledIn,
    output cpuWriteEnabledIn,
    input  cpuReadEnabledOut,
    input  cpuWriteEnabledOut,
    output cpuFunctionComplete,
    output cpuHit,
    output cpuCommandOut,
    output cpuGrant,
    output snoopAddress,
    output snoopCommandIn,
    input  snoopCommandOut,
    output snoopHit,
    output snoopIsInvalidatedIn,
    input  snoopIsInvalidatedOut,
    output snoopReadEnabledIn,
    input  snoopReadEnabledOut,
    input  starvationEvent
  );

  modport slave (
    input  cpuAddress,
    input  cpuReadEnabledIn,
    input  cpuWriteEnabledIn,
    output cpuReadEnabledOut,
    output cpuWriteEnabledOut,
    input  cpuFunctionComplete,
    input  cpuHit,
    input  cpuCommandOut,
    input  cpuGrant,
    input  snoopAddress,
    input  snoopCommandIn,
    output snoopCommandOut,
    input  snoopHit,
    input  snoopIsInvalidatedIn,
    output snoopIsInvalidatedOut,
    input  snoopReadEnabledIn,
    output snoopReadEnabledOut,
    output starvationEvent
  );

endinterface

// File: rtl/concurrency_guard_conflict_detector.sv
// Per-port detection of self-snoop loops and CPU/snoop line conflicts.
// Offset bits are ignored so any access within one block collides.
module conflict_detector
  import commands::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
  input  logic [ADDRESS_WIDTH-1:0] snoopAddress,
  input  logic cpuRead,
  input  logic cpuWrite,
  input  logic cpuHit,
  input  logic cpuGrant,
  input  Command cpuCommand,
  input  Command snoopCommand,
  input  logic snoopHit,
  output logic loop,
  output logic conflict
);

  logic tag_match;
  logic excl;
  logic rd_clash;
  logic wr_clash;
  logic unused_offset;

  assign unused_offset = ^{cpuAddress[OFFSET_WIDTH-1:0],
                           snoopAddress[OFFSET_WIDTH-1:0]};

  assign tag_match =
    cpuAddress[ADDRESS_WIDTH-1:OFFSET_WIDTH] ==
    snoopAddress[ADDRESS_WIDTH-1:OFFSET_WIDTH];

  assign excl = is_exclusive(snoopCommand);

  // Our own invalidate seen coming back on the bus.
  assign loop = tag_match & cpuGrant & excl &
                (cpuCommand == snoopCommand);

  assign rd_clash = cpuRead & excl;
  assign wr_clash = cpuWrite &
                    (excl | (snoopCommand == BUS_READ));

  assign conflict = ~loop & tag_match & cpuHit & snoopHit &
                    (rd_clash | wr_clash);

endmodule

// File: rtl/concurrency_guard.sv
// Arbitrates a cache line between the CPU and snoop ports when both
// touch it, with a hold limit so the CPU cannot starve.
module concurrency_guard
  import commands::*;
  import concurrency_guard_types::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int OFFSET_WIDTH = 4,
  parameter int SNOOP_PORTS = 2,
  parameter int MAX_HOLD = 8
) (
  input logic clock,
  input logic reset,
  concurrency_guard_if.slave bus
);

  localparam int IW = (SNOOP_PORTS > 1) ? $clog2(SNOOP_PORTS) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  logic [SNOOP_PORTS-1:0] loop;
  logic [SNOOP_PORTS-1:0] conflict;
  logic [SNOOP_PORTS-1:0] held;
  logic [IW-1:0] first_idx;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] owner_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  guard_state_t state_q;
  guard_state_t state_d;
  logic cpu_block;
  logic starve;

  for (genvar i = 0; i < SNOOP_PORTS; i++) begin : g_port
    conflict_detector #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH),
      .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_det (
      .cpuAddress(bus.cpuAddress),
      .snoopAddress(bus.snoopAddress[i]),
      .cpuRead(bus.cpuReadEnabledIn),
      .cpuWrite(bus.cpuWriteEnabledIn),
      .cpuHit(bus.cpuHit),
      .cpuGrant(bus.cpuGrant),
      .cpuCommand(bus.cpuCommandOut),
      .snoopCommand(bus.snoopCommandIn[i]),
      .snoopHit(bus.snoopHit[i]),
      .loop(loop[i]),
      .conflict(conflict[i])
    );
  end

  always_comb begin
    first_idx = '0;
    for (int i = SNOOP_PORTS - 1; i >= 0; i--) begin
      if (conflict[i]) first_idx = IW'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      count_q <= count_d;
    end
  end

  // count_q tracks cycles the CPU has been held, including the first.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    count_d = count_q;
    held = '0;
    cpu_block = 1'b0;
    starve = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|conflict) begin
          owner_d = first_idx;
          held = conflict;
          if (bus.cpuFunctionComplete) begin
            state_d = CPU_OWNS;
            count_d = '0;
          end else begin
            state_d = SNOOP_OWNS;
            count_d = CW'(1);
            cpu_block = 1'b1;
            held[first_idx] = 1'b0;
          end
        end
      end
      SNOOP_OWNS: begin
        cpu_block = 1'b1;
        held = conflict;
        held[owner_q] = 1'b0;
        if (!conflict[owner_q]) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == LAST) begin
          state_d = CPU_OWNS;
          count_d = '0;
          starve = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      CPU_OWNS: begin
        held = conflict;
        count_d = '0;
        if (bus.cpuFunctionComplete || !conflict[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.cpuReadEnabledOut = 1'b0;
    bus.cpuWriteEnabledOut = 1'b0;
    bus.starvationEvent = 1'b0;
    bus.snoopReadEnabledOut = '0;
    bus.snoopIsInvalidatedOut = '0;
    for (int i = 0; i < SNOOP_PORTS; i++) begin
      bus.snoopCommandOut[i] = NONE;
    end
    if (!reset) begin
      bus.cpuReadEnabledOut = bus.cpuReadEnabledIn & ~cpu_block;
      bus.cpuWriteEnabledOut = bus.cpuWriteEnabledIn & ~cpu_block;
      bus.starvationEvent = starve;
      bus.snoopReadEnabledOut = bus.snoopReadEnabledIn | held;
      bus.snoopIsInvalidatedOut = bus.snoopIsInvalidatedIn | loop;
      for (int i = 0; i < SNOOP_PORTS; i++) begin
        if (!(held[i] || loop[i])) begin
          bus.snoopCommandOut[i] = bus.snoopCommandIn[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_concurrency_guard.sv
// Directed scenarios plus sticky random traffic against a
// cycle-level reference model of the guard's arbitration rules.
module tb_concurrency_guard;
  import commands::*;
  import concurrency_guard_types::*;

  localparam int AW = 16;
  localparam int OW = 4;
  localparam int SP = 2;
  localparam int MH = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  concurrency_guard_if #(
    .ADDRESS_WIDTH(AW),
    .SNOOP_PORTS(SP)
  ) bus ();

  concurrency_guard #(
    .ADDRESS_WIDTH(AW),
    .OFFSET_WIDTH(OW),
    .SNOOP_PORTS(SP),
    .MAX_HOLD(MH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: 0 free, 1 snoop side owns, 2 cpu side owns
  int m_mode = 0;
  int m_owner = 0;
  int m_hc = 0;
  int n_mode, n_owner, n_hc;
  logic [31:0] m_exp;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_outs();
    logic [31:0] v;
    v = '0;
    v[0] = bus.cpuReadEnabledOut;
    v[1] = bus.cpuWriteEnabledOut;
    v[2] = bus.starvationEvent;
    for (int i = 0; i < SP; i++) begin
      v[3+5*i +: 3] = bus.snoopCommandOut[i];
      v[6+5*i] = bus.snoopReadEnabledOut[i];
      v[7+5*i] = bus.snoopIsInvalidatedOut[i];
    end
    return v;
  endfunction

  function automatic bit excl(input Command c);
    return c == BUS_INVALIDATE || c == BUS_READ_EXCLUSIVE;
  endfunction

  task automatic model_eval();
    bit lp [SP];
    bit cf [SP];
    bit hold [SP];
    bit blocked;
    bit starv;
    bit match;
    int first;
    blocked = 0;
    starv = 0;
    first = -1;
    n_mode = m_mode;
    n_owner = m_owner;
    n_hc = m_hc;
    for (int i = 0; i < SP; i++) begin
      Command sc;
      sc = bus.snoopCommandIn[i];
      match = (int'(bus.cpuAddress) >> OW) ==
              (int'(bus.snoopAddress[i]) >> OW);
      lp[i] = match && bus.cpuGrant &&
              bus.cpuCommandOut == sc && excl(sc);
      cf[i] = !lp[i] && match && bus.cpuHit && bus.snoopHit[i] &&
              ((bus.cpuReadEnabledIn && excl(sc)) ||
               (bus.cpuWriteEnabledIn && (sc == BUS_READ || excl(sc))));
      hold[i] = 0;
      if (cf[i] && first < 0) first = i;
    end
    m_exp = '0;
    if (reset) begin
      n_mode = 0;
      n_owner = 0;
      n_hc = 0;
      for (int i = 0; i < SP; i++) m_exp[3+5*i +: 3] = NONE;
      return;
    end
    case (m_mode)
      0: if (first >= 0) begin
        n_owner = first;
        for (int i = 0; i < SP; i++) hold[i] = cf[i];
        if (bus.cpuFunctionComplete) begin
          n_mode = 2;
          n_hc = 0;
        end else begin
          n_mode = 1;
          n_hc = 1;
          blocked = 1;
          hold[first] = 0;
        end
      end
      1: begin
        blocked = 1;
        for (int i = 0; i < SP; i++) hold[i] = cf[i] && i != m_owner;
        if (!cf[m_owner]) begin
          n_mode = 0;
          n_hc = 0;
        end else if (m_hc == MH - 1) begin
          starv = 1;
          n_mode = 2;
          n_hc = 0;
        end else begin
          n_hc = m_hc + 1;
        end
      end
      default: begin
        for (int i = 0; i < SP; i++) hold[i] = cf[i];
        if (bus.cpuFunctionComplete || !cf[m_owner]) n_mode = 0;
      end
    endcase
    m_exp[0] = bus.cpuReadEnabledIn && !blocked;
    m_exp[1] = bus.cpuWriteEnabledIn && !blocked;
    m_exp[2] = starv;
    for (int i = 0; i < SP; i++) begin
      m_exp[3+5*i +: 3] = (hold[i] || lp[i]) ? NONE : bus.snoopCommandIn[i];
      m_exp[6+5*i] = hold[i] || bus.snoopReadEnabledIn[i];
      m_exp[7+5*i] = lp[i] || bus.snoopIsInvalidatedIn[i];
    end
  endtask

  // inputs are set at the negedge; one clock is checked and consumed
  task automatic cycle(input string tag);
    #1;
    model_eval();
    check(tag, dut_outs(), m_exp);
    @(posedge clock);
    m_mode = n_mode;
    m_owner = n_owner;
    m_hc = n_hc;
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus.cpuAddress = '0;
    bus.cpuReadEnabledIn = 0;
    bus.cpuWriteEnabledIn = 0;
    bus.cpuFunctionComplete = 0;
    bus.cpuHit = 0;
    bus.cpuCommandOut = NONE;
    bus.cpuGrant = 0;
    bus.snoopHit = '0;
    bus.snoopIsInvalidatedIn = '0;
    bus.snoopReadEnabledIn = '0;
    for (int i = 0; i < SP; i++) begin
      bus.snoopAddress[i] = '0;
      bus.snoopCommandIn[i] = NONE;
    end
  endtask

  task automatic write_vs_read(input logic complete);
    clear_inputs();
    bus.cpuAddress = 16'h1230;
    bus.cpuWriteEnabledIn = 1;
    bus.cpuHit = 1;
    bus.cpuFunctionComplete = complete;
    bus.snoopAddress[0] = 16'h1238;
    bus.snoopCommandIn[0] = BUS_READ;
    bus.snoopHit[0] = 1;
  endtask

  task automatic randomize_inputs();
    logic [AW-1:0] a;
    a = AW'($urandom_range(16'h123, 16'h124)) << OW;
    bus.cpuAddress = a | AW'($urandom_range(0, 15));
    bus.cpuReadEnabledIn = 1'($urandom_range(0, 1));
    bus.cpuWriteEnabledIn = 1'($urandom_range(0, 1));
    bus.cpuFunctionComplete = ($urandom_range(0, 5) == 0);
    bus.cpuHit = ($urandom_range(0, 3) != 0);
    bus.cpuCommandOut = Command'($urandom_range(0, 4));
    bus.cpuGrant = 1'($urandom_range(0, 1));
    for (int i = 0; i < SP; i++) begin
      a = AW'($urandom_range(16'h123, 16'h124)) << OW;
      bus.snoopAddress[i] = a | AW'($urandom_range(0, 15));
      bus.snoopCommandIn[i] = Command'($urandom_range(0, 4));
      bus.snoopHit[i] = ($urandom_range(0, 3) != 0);
      bus.snoopIsInvalidatedIn[i] = 1'($urandom_range(0, 1));
      bus.snoopReadEnabledIn[i] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    @(negedge clock);
    cycle("reset_a");
    cycle("reset_b");
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    check("reset_count", 32'(dut.count_q), 0);
    reset = 0;

    write_vs_read(1'b0);
    #1;
    check("r19_wr_out", 32'(bus.cpuWriteEnabledOut), 0);
    check("r19_cmd0", 32'(bus.snoopCommandOut[0]), 32'(BUS_READ));
    cycle("r19");
    check("r19_state", 32'(dut.state_q), 32'(SNOOP_OWNS));
    bus.snoopHit[0] = 0;
    cycle("r19_release");
    check("r19_idle", 32'(dut.state_q), 32'(IDLE));

    write_vs_read(1'b1);
    #1;
    check("r20_cmd0", 32'(bus.snoopCommandOut[0]), 32'(NONE));
    check("r20_rd0", 32'(bus.snoopReadEnabledOut[0]), 1);
    check("r20_wr_out", 32'(bus.cpuWriteEnabledOut), 1);
    cycle("r20");
    check("r20_state", 32'(dut.state_q), 32'(CPU_OWNS));
    cycle("r20_done");
    check("r20_idle", 32'(dut.state_q), 32'(IDLE));
    clear_inputs();
    cycle("r20_clear");

    write_vs_read(1'b0);
    for (int k = 1; k <= MH; k++) begin
      #1;
      check($sformatf("r21_starv_%0d", k),
            32'(bus.starvationEvent), 32'(k == MH));
      cycle("r21_hold");
    end
    #1;
    check("r21_cpu_free", 32'(bus.cpuWriteEnabledOut), 1);
    check("r21_snoop_held", 32'(bus.snoopCommandOut[0]), 32'(NONE));
    cycle("r21_after");

    clear_inputs();
    cycle("r22_clear");
    bus.cpuGrant = 1;
    bus.cpuCommandOut = BUS_INVALIDATE;
    bus.cpuAddress = 16'h4560;
    bus.snoopAddress[0] = 16'h4560;
    bus.snoopCommandIn[0] = BUS_INVALIDATE;
    #1;
    check("r22_inv0", 32'(bus.snoopIsInvalidatedOut[0]), 1);
    check("r22_cmd0", 32'(bus.snoopCommandOut[0]), 32'(NONE));
    cycle("r22");
    check("r22_state", 32'(dut.state_q), 32'(IDLE));

    write_vs_read(1'b0);
    bus.snoopAddress[1] = 16'h123f;
    bus.snoopCommandIn[1] = BUS_READ_EXCLUSIVE;
    bus.snoopHit[1] = 1;
    #1;
    check("r23_cmd1", 32'(bus.snoopCommandOut[1]), 32'(NONE));
    check("r23_rd1", 32'(bus.snoopReadEnabledOut[1]), 1);
    check("r23_cmd0", 32'(bus.snoopCommandOut[0]), 32'(BUS_READ));
    cycle("r23");
    check("r23_owner", 32'(dut.owner_q), 0);
    cycle("r23_hold");
    reset = 1;
    cycle("r23_reset");
    check("r23_state", 32'(dut.state_q), 32'(IDLE));
    check("r23_count", 32'(dut.count_q), 0);
    reset = 0;

    clear_inputs();
    randomize_inputs();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) randomize_inputs();
      reset = ($urandom_range(0, 59) == 0);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
